// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan of the four Basys-3 seven-segment
// digits. Each digit owns a fixed slot of REFRESH_DIV cycles: the first
// BLANK_CYCLES cycles keep every anode off to prevent ghosting, and the rest
// of the slot shows that digit. Per-digit enables and optional leading-zero
// suppression decide whether a slot lights. All outputs are registered.
// BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < REFRESH_DIV.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 25000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_a,
  input  logic [3:0] digit_b,
  input  logic [3:0] digit_c,
  input  logic [3:0] digit_d,
  input  logic [3:0] digit_en,
  input  logic       lz_blank,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [1:0] digit_idx,
  output logic       frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    cur_digit;
  logic          lz_hit;
  logic          visible;
  logic [3:0]    an_show;

  // Active-low decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Pick the live digit for the slot about to be shown; slot 3 is digit_a.
  always_comb begin
    cur_digit = digit_d;
    case (digit_idx)
      2'd3:    cur_digit = digit_a;
      2'd2:    cur_digit = digit_b;
      2'd1:    cur_digit = digit_c;
      default: cur_digit = digit_d;
    endcase
  end

  // Leading-zero chain looks only at digit values, never at the enables,
  // so a disabled nonzero digit still stops suppression to its right.
  always_comb begin
    lz_hit = 1'b0;
    if (lz_blank) begin
      case (digit_idx)
        2'd3:    lz_hit = (digit_a == 4'd0);
        2'd2:    lz_hit = (digit_a == 4'd0) && (digit_b == 4'd0);
        2'd1:    lz_hit = (digit_a == 4'd0) && (digit_b == 4'd0) &&
                          (digit_c == 4'd0);
        default: lz_hit = 1'b0;
      endcase
    end
    visible = digit_en[digit_idx] && !lz_hit;
    an_show = ~(4'b0001 << digit_idx);
  end

  // Slot sequencer: the BLANK->SHOW edge latches the decoded digit and anode
  // pattern, so input changes during SHOW cannot tear the display; the end of
  // SHOW blanks, advances the slot and flags the end of a frame after slot 3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      digit_idx  <= 2'd0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (state == ST_BLANK) begin
        cnt <= cnt + 1'b1;
        if (cnt == BLANK_LAST) begin
          state <= ST_SHOW;
          if (visible) begin
            an  <= an_show;
            seg <= decode(cur_digit);
          end else begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
          end
        end
      end else begin
        if (cnt == LAST_CNT) begin
          state      <= ST_BLANK;
          cnt        <= '0;
          digit_idx  <= digit_idx + 2'd1;
          an         <= AN_OFF;
          seg        <= SEG_OFF;
          frame_tick <= (digit_idx == 2'd3);
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed and random stimulus for seg_scan_ctrl with a
// small slot/frame arithmetic model of the expected display.
module tb_seg_scan_ctrl;

  localparam int RDIV  = 8;
  localparam int BLANK = 2;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit_a = '0, digit_b = '0, digit_c = '0, digit_d = '0;
  logic [3:0] digit_en = '0;
  logic       lz_blank = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic [1:0] digit_idx;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Inputs as seen at the latest slot sampling edge, indexed by anode position.
  logic [3:0] snap_dig [4];
  logic [3:0] snap_en;
  logic       snap_lz;

  seg_scan_ctrl #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .reset(reset),
    .digit_a(digit_a), .digit_b(digit_b), .digit_c(digit_c), .digit_d(digit_d),
    .digit_en(digit_en), .lz_blank(lz_blank),
    .seg(seg), .an(an), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [3:0] d,
                               input logic [3:0] en, input logic lz);
    digit_a  = a;
    digit_b  = b;
    digit_c  = c;
    digit_d  = d;
    digit_en = en;
    lz_blank = lz;
  endtask

  task automatic compare(input string tag, input logic [6:0] obs,
                         input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic lz_hidden(input int slot);
    if (!snap_lz || slot == 0) return 1'b0;
    for (int p = 3; p >= slot; p--)
      if (snap_dig[p] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  // Expected outputs from slot arithmetic on the cycle count since reset.
  task automatic checkOutput();
    int slot, pos;
    logic [3:0] exp_an, one_hot;
    logic [6:0] exp_seg;
    logic       vis;
    slot = (cyc / RDIV) % 4;
    pos  = cyc % RDIV;
    exp_an  = 4'b1111;
    exp_seg = 7'b1111111;
    if (pos >= BLANK) begin
      vis = snap_en[slot] && !lz_hidden(slot);
      if (vis) begin
        one_hot = 4'b0001 << slot;
        exp_an  = ~one_hot;
        exp_seg = SEG_TABLE[snap_dig[slot]];
      end
    end
    compare("an", {3'b000, an}, {3'b000, exp_an});
    compare("seg", seg, exp_seg);
    compare("digit_idx", {5'b0, digit_idx}, 7'(slot));
    compare("frame_tick", {6'b0, frame_tick},
            {6'b0, (cyc > 0 && cyc % (4 * RDIV) == 0)});
  endtask

  // Advance one clock; the inputs present just before the edge that enters
  // SHOW are the ones the display must use for the whole slot.
  task automatic run_cycle();
    if (cyc % RDIV == BLANK - 1) begin
      snap_dig[3] = digit_a;
      snap_dig[2] = digit_b;
      snap_dig[1] = digit_c;
      snap_dig[0] = digit_d;
      snap_en     = digit_en;
      snap_lz     = lz_blank;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    for (int p = 0; p < 4; p++) snap_dig[p] = 4'd0;
    snap_en = 4'd0;
    snap_lz = 1'b0;
    checkOutput();
  endtask

  initial begin
    $display("[TB] start");

    // Scan timing with 1,2,3,4 on all digits.
    applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'b1111, 1'b0);
    do_reset();
    run_cycles(40);

    // Decode sweep on digit_d, one value per frame.
    do_reset();
    for (int v = 0; v < 16; v++) begin
      applyStimulus(4'd1, 4'd2, 4'd3, 4'(v), 4'b1111, 1'b0);
      run_cycles(4 * RDIV);
    end

    // Leading-zero suppression, then all zeros, then suppression off.
    applyStimulus(4'd0, 4'd0, 4'd0, 4'd5, 4'b1111, 1'b1);
    run_cycles(4 * RDIV);
    applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 4'b1111, 1'b1);
    run_cycles(4 * RDIV);
    applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 4'b1111, 1'b0);
    run_cycles(4 * RDIV);

    // Disabled nonzero A still stops suppression of B.
    applyStimulus(4'd7, 4'd0, 4'd0, 4'd3, 4'b0111, 1'b1);
    run_cycles(4 * RDIV);

    // Enables 0101.
    applyStimulus(4'd8, 4'd9, 4'hA, 4'hB, 4'b0101, 1'b0);
    run_cycles(8 * RDIV);

    // Mid-slot change of digit_d from 4 to 9 at cycle 4.
    applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'b1111, 1'b0);
    do_reset();
    run_cycles(4);
    applyStimulus(4'd1, 4'd2, 4'd3, 4'd9, 4'b1111, 1'b0);
    run_cycles(36);

    // Asynchronous reset in the middle of slot 1.
    do_reset();
    run_cycles(13);
    #1 reset = 1'b1;
    #1;
    compare("async_rst_an", {3'b000, an}, 7'b0001111);
    compare("async_rst_seg", seg, 7'b1111111);
    compare("async_rst_idx", {5'b0, digit_idx}, 7'd0);
    compare("async_rst_tick", {6'b0, frame_tick}, 7'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    checkOutput();
    run_cycles(40);

    // Random inputs, changed at random cycles.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0)
        applyStimulus(4'($urandom_range(0, 15)) & {4{$urandom_range(0, 1) == 1}},
                      4'($urandom_range(0, 15)) & {4{$urandom_range(0, 1) == 1}},
                      4'($urandom_range(0, 15)) & {4{$urandom_range(0, 1) == 1}},
                      4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)));
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexing scheduler for the four-digit Basys-3 seven-segment display.
- Inputs: four 4-bit hex digit values, one per display position, produced by the switch/input-select datapath.
- Drives the shared active-low seg/an pins one digit at a time, with a dead-time blanking gap between digits, per-digit enables and optional leading-zero suppression.
- Sits between the digit-selection logic and the board pins in the lab top level.

Parameters:
- REFRESH_DIV, 25000: clock cycles per digit slot (100 MHz → 4 kHz slot rate, 1 kHz frame rate).
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off (anti-ghosting). Constraint: 1 ≤ BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-high reset
- digit_a  input  4  hex value for leftmost digit (an[3])
- digit_b  input  4  hex value for an[2]
- digit_c  input  4  hex value for an[1]
- digit_d  input  4  hex value for rightmost digit (an[0])
- digit_en  input  4  per-digit enable; bit i enables an[i]
- lz_blank  input  1  1 = suppress leading zeros
- seg  output  7  active-low cathodes; seg[0]=a … seg[6]=g
- an  output  4  active-low anodes
- digit_idx  output  2  slot currently scheduled; 0 = an[0] … 3 = an[3]
- frame_tick  output  1  one-cycle pulse at end of each full 4-slot frame

Behaviour:
Interface
- One clock, clk. Reset is asynchronous, active-high, port reset.
- All outputs are registered.

Reset values
- an = 4'b1111, seg = 7'b1111111, digit_idx = 0, frame_tick = 0.
- FSM = BLANK, slot counter = 0.
- Asserting reset mid-slot forces these values immediately. After release, the first clk edge begins counting BLANK for slot 0.

FSM (two states, one counter 0..REFRESH_DIV-1)
- BLANK:
  - an = 4'b1111, seg = 7'b1111111.
  - Stays BLANK_CYCLES cycles, then moves to SHOW.
  - On the BLANK→SHOW edge, the digit for the current slot is sampled into a holding register. Input changes during SHOW are ignored until the next slot, so there is no tearing.
- SHOW:
  - Lasts REFRESH_DIV − BLANK_CYCLES cycles.
  - an[digit_idx] = 0 only if the slot is visible (see Visibility); all other an bits = 1.
  - seg = decoded value of the held digit; all ones if the slot is not visible.
  - On exit: state → BLANK, counter → 0, digit_idx increments mod 4 (3 wraps to 0).
  - On exit from slot 3, frame_tick = 1 for exactly that one cycle.
- Slot period = REFRESH_DIV cycles exactly. Frame period = 4 × REFRESH_DIV cycles.
- an and seg change on the same clk edge as the state transition.

Visibility
- Slot i is visible iff digit_en[i] = 1 AND the digit is not leading-zero blanked.
- A disabled slot still consumes its full time (constant refresh rate).

Leading-zero blanking (lz_blank = 1, evaluated on the sampled values)
- A blanked iff A = 0.
- B blanked iff A = 0 and B = 0.
- C blanked iff A = B = C = 0.
- D is never blanked, so value 0 always shows one "0".
- digit_en does not affect the leading-zero chain: a disabled nonzero A still stops suppression of B.

Decode (active-low, {g,f,e,d,c,b,a})
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
- 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
- 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
- C = 1000110, d = 0100001, E = 0000110, F = 0001110
- No decimal point is driven.

Test Plan:
(All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2 unless noted.)
1. Scan timing, digits A..D = 1,2,3,4, en = 1111, lz = 0, release reset:
   - cycles 0-1: an = 1111.
   - cycles 2-7: an = 1110, seg = 0011001.
   - cycles 8-9: blank.
   - cycles 10-15: an = 1101, seg = 0110000.
   - Continues in order 1011, 0111. frame_tick high only at the cycle-31→32 edge; digit_idx sequence 0,1,2,3,0.
2. Decode sweep: digit_d stepped through 0..F, one value per frame → seg in an[0] slot matches all 16 table entries.
3. Leading-zero blanking: A..D = 0,0,0,5, lz = 1 → only the an[0] slot lights (seg = 0010010). Then A..D = 0,0,0,0 → only an[0] lights, seg = 1000000. Then lz = 0 → all four slots show 1000000.
4. Enables: digit_en = 0101 → an[1] and an[3] stay high during their SHOW windows; slot timing and frame_tick period remain 32 cycles.
5. Mid-slot change: digit_d changes 4→9 at cycle 4 (inside SHOW) → seg holds 0011001 through cycle 7; 9 (0010000) first appears at cycle 34.
6. Reset mid-operation: assert reset at cycle 13, asynchronously between edges → an = 1111, seg = 1111111, digit_idx = 0 before the next clk edge. After release, slot 0 SHOW begins 2 cycles later.
